decoder_n_scan: RTL and testbench

DECODER_N_SCAN -- requirements
Module: decoder_n_scan

---
 rtl/decoder_pkg.sv | 28 ++
 rtl/dwell_counter.sv | 42 ++++
 rtl/decoder_n_scan.sv | 138 +++++++++++++
 tb/tb_decoder_n_scan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg
//   Shared definitions for decoder_n_scan and its dwell counter:
//   - state_e       : FSM state encoding (IDLE / DECODE / SCAN)
//   - N_MIN..N_MAX  : legal range of the select width N
//   - DWELL_MIN/MAX : legal range of the scan dwell length
//   - n_legal/dwell_legal : parameter-range helpers used for elaboration checks
package decoder_pkg;

  localparam int N_MIN     = 1;
  localparam int N_MAX     = 6;
  localparam int DWELL_MIN = 1;
  localparam int DWELL_MAX = 65535;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_e;

  function automatic bit n_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

  function automatic bit dwell_legal(input int d);
    return (d >= DWELL_MIN) && (d <= DWELL_MAX);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter
//   Counts 0..DWELL-1 while inc is high, wrapping to 0 after the last count.
//   Ports:
//     clk    - clock, rising edge
//     rst    - synchronous active-high reset, clears the count
//     clr    - synchronous clear (priority over inc)
//     inc    - advance the count this cycle
//     expire - count currently sits at DWELL-1; the next inc wraps it
module dwell_counter
  import decoder_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  if (!dwell_legal(DWELL)) begin : g_bad_dwell
    $error("dwell_counter: DWELL=%0d outside %0d..%0d", DWELL, DWELL_MIN, DWELL_MAX);
  end

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;

  // Terminal-count flag is not gated by inc so the parent can read it
  // inside the same combinational block that drives inc.
  assign expire = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= expire ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/decoder_n_scan.sv
// decoder_n_scan
//   N-to-2**N one-hot decoder with an auto-scan mode.
//   Decode mode: each accepted y produces D = 1<<y one cycle later and holds.
//   Scan mode  : D walks 1<<sel, sel advancing every DWELL cycles and wrapping.
//   Ports:
//     clk     - clock, rising edge
//     rst     - synchronous active-high reset
//     en      - block enable; while low, D/D_valid read 0 and all state freezes
//     mode    - 0 = decode, 1 = scan
//     y       - binary select (decode mode)
//     y_valid - y is valid
//     y_ready - en & ~mode; accept = y_valid & y_ready
//     D       - one-hot (or all-zero) output
//     D_valid - D holds a valid one-hot value
//     sel     - index of the asserted D bit
module decoder_n_scan
  import decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        y,
  input  logic                y_valid,
  output logic                y_ready,
  output logic [(1<<N)-1:0]   D,
  output logic                D_valid,
  output logic [N-1:0]        sel
);

  if (!n_legal(N)) begin : g_bad_n
    $error("decoder_n_scan: N=%0d outside %0d..%0d", N, N_MIN, N_MAX);
  end
  if (!dwell_legal(DWELL)) begin : g_bad_dwell
    $error("decoder_n_scan: DWELL=%0d outside %0d..%0d", DWELL, DWELL_MIN, DWELL_MAX);
  end

  localparam int W = 1 << N;

  state_e         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [W-1:0]   d_q, d_d;
  logic           valid_q, valid_d;
  logic           accept;
  logic           cnt_clr, cnt_inc, cnt_expire;

  assign y_ready = en & ~mode;
  assign accept  = y_valid & y_ready;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .expire (cnt_expire)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (mode) begin
            state_d = SCAN;
            valid_d = 1'b1;
            cnt_clr = 1'b1;
          end else if (accept) begin
            state_d = DECODE;
            sel_d   = y;
            valid_d = 1'b1;
          end
        end
        DECODE: begin
          if (mode) begin
            // Scan resumes from whatever sel currently shows.
            state_d = SCAN;
            valid_d = 1'b1;
            cnt_clr = 1'b1;
          end else if (accept) begin
            sel_d   = y;
            valid_d = 1'b1;
          end
        end
        SCAN: begin
          if (!mode) begin
            // Mode change wins over a coinciding dwell expiry: sel holds.
            state_d = DECODE;
            if (accept) begin
              sel_d = y;
            end
          end else begin
            cnt_inc = 1'b1;
            if (cnt_expire) begin
              sel_d = sel_q + N'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    d_d = '0;
    if (valid_d) begin
      d_d[sel_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      d_q     <= d_d;
      valid_q <= valid_d;
    end
  end

  // Registered value is masked while disabled so D reads zero immediately,
  // while the underlying registers keep their frozen contents for resume.
  assign D       = en ? d_q : '0;
  assign D_valid = en & valid_q;
  assign sel     = sel_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// tb_decoder_n_scan
//   Scoreboard bench for decoder_n_scan (N=3, DWELL=4). The stimulus process
//   pushes hand-computed expected outputs tagged with the cycle they are due;
//   a monitor pops and compares them on the falling edge.
module tb_decoder_n_scan;
  import decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, mode, y_valid;
  logic [2:0] y;
  logic       y_ready;
  logic [7:0] D;
  logic       D_valid;
  logic [2:0] sel;

  int cyc    = 0;
  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    int         due;
    logic       is_rdy;
    logic [7:0] d;
    logic       dv;
    logic [2:0] s;
    state_e     st;
    logic       rdy;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];

  decoder_n_scan #(
    .N     (3),
    .DWELL (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .D       (D),
    .D_valid (D_valid),
    .sel     (sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic m, input logic v, input logic [2:0] yy);
    en = e; mode = m; y_valid = v; y = yy;
  endtask

  task automatic push(input exp_t e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic obs_on(input logic [2:0] s, input state_e st, input string nm);
    exp_t e;
    e.due = cyc; e.is_rdy = 1'b0; e.d = 8'b1 << s; e.dv = 1'b1;
    e.s = s; e.st = st; e.rdy = 1'b0;
    push(e, nm);
  endtask

  task automatic obs_off(input logic [2:0] s, input state_e st, input string nm);
    exp_t e;
    e.due = cyc; e.is_rdy = 1'b0; e.d = 8'h00; e.dv = 1'b0;
    e.s = s; e.st = st; e.rdy = 1'b0;
    push(e, nm);
  endtask

  task automatic obs_rdy(input logic r, input string nm);
    exp_t e;
    e.due = cyc; e.is_rdy = 1'b1; e.d = 8'h00; e.dv = 1'b0;
    e.s = 3'd0; e.st = IDLE; e.rdy = r;
    push(e, nm);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      ntests++;
      if (e.due < cyc) begin
        nfail++;
        $display("FAIL %s: check due cycle %0d seen at cycle %0d", nm, e.due, cyc);
      end else if (e.is_rdy) begin
        if (y_ready !== e.rdy) begin
          nfail++;
          $display("FAIL %s @%0d: y_ready=%b expected %b", nm, cyc, y_ready, e.rdy);
        end
      end else if (D !== e.d || D_valid !== e.dv || sel !== e.s || dut.state_q !== e.st) begin
        nfail++;
        $display("FAIL %s @%0d: D=%b D_valid=%b sel=%0d state=%0d expected D=%b D_valid=%b sel=%0d state=%0d",
                 nm, cyc, D, D_valid, sel, dut.state_q, e.d, e.dv, e.s, e.st);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0);

    // Reset state; input offered during reset is discarded
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'd5);
    obs_off(3'd0, IDLE, "reset_state");
    obs_rdy(1'b1, "rdy_in_reset");
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'd0);
    obs_off(3'd0, IDLE, "reset_discard");
    obs_rdy(1'b1, "rdy_decode");

    // Decode sweep, one accept per cycle
    for (int i = 1; i < 8; i++) begin
      tick();
      drive(1'b1, 1'b0, 1'b1, 3'(i));
      obs_on(3'(i - 1), DECODE, "decode_sweep");
      obs_rdy(1'b1, "rdy_decode");
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    obs_on(3'd7, DECODE, "decode_sweep");
    tick();
    obs_on(3'd7, DECODE, "decode_hold");

    // Reset overriding a scan request and a pending y
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3'd7);
    obs_on(3'd7, DECODE, "decode_hold");
    obs_rdy(1'b0, "rdy_scan");
    tick();
    rst = 1'b0;
    obs_off(3'd0, IDLE, "reset_over_mode");
    obs_rdy(1'b0, "rdy_scan");

    // Scan wrap from reset with y_valid/y=111 ignored
    for (int j = 0; j < 54; j++) begin
      tick();
      obs_on(3'((j / 4) % 8), SCAN, "scan_wrap");
      obs_rdy(1'b0, "ignored_y");
    end

    // Enable freeze at sel=5, dwell=2
    for (int k = 0; k < 3; k++) begin
      tick();
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      obs_off(3'd5, SCAN, "freeze");
      obs_rdy(1'b0, "rdy_disabled");
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    obs_on(3'd5, SCAN, "resume");
    tick();
    obs_on(3'd5, SCAN, "resume");
    tick();
    obs_on(3'd6, SCAN, "resume_advance");

    // Mode handoff: leave scan, accept y=011, scan again from sel=3
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    obs_on(3'd6, SCAN, "resume_advance");
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'd3);
    obs_on(3'd6, DECODE, "scan_to_decode");
    obs_rdy(1'b1, "rdy_decode");
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    obs_on(3'd3, DECODE, "handoff_accept");
    for (int t = 0; t < 12; t++) begin
      tick();
      obs_on(3'(3 + t / 4), SCAN, "handoff_scan");
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    obs_on(3'd6, SCAN, "handoff_scan");
    tick();
    obs_on(3'd6, DECODE, "handoff_hold");
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'd1);
    obs_on(3'd6, DECODE, "handoff_hold");
    obs_rdy(1'b1, "rdy_decode");
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    obs_on(3'd1, DECODE, "handoff_new_y");

    // Mode drop coinciding with dwell expiry: sel must not advance
    for (int t = 0; t < 4; t++) begin
      tick();
      if (t == 3) drive(1'b1, 1'b0, 1'b0, 3'd0);
      obs_on(3'd1, SCAN, "expire_vs_mode");
    end
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    obs_on(3'd1, DECODE, "expire_vs_mode");

    // Reset mid-scan at sel=4
    for (int t = 0; t < 13; t++) begin
      tick();
      obs_on(3'(1 + t / 4), SCAN, "prereset_scan");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0);
    obs_off(3'd0, IDLE, "reset_mid_scan");
    tick();
    obs_off(3'd0, IDLE, "idle_disabled");

    @(negedge clk);
    #1;
    ntests++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d checks left unconsumed, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
